vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 137 +++++++++++++
 tb/tb_vga_timing_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-tick divider, h/v counters, pixel fetch strobe and a
// tick-advanced pipeline that lines blanking/syncs up with colour returned by a fixed-latency source.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   COLOR_W  = 4,
    parameter int   PIX_DIV  = 2,
    parameter int   RD_LAT   = 2,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic                          enable,
    output logic                          pix_req,
    output logic [$clog2(H_ACTIVE)-1:0]   pix_x,
    output logic [$clog2(V_ACTIVE)-1:0]   pix_y,
    input  logic [3*COLOR_W-1:0]          pix_rgb,
    output logic [COLOR_W-1:0]            vga_port_red,
    output logic [COLOR_W-1:0]            vga_port_green,
    output logic [COLOR_W-1:0]            vga_port_blue,
    output logic                          vga_port_hs,
    output logic                          vga_port_vs,
    output logic                          frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = $clog2(H_ACTIVE);
    localparam int YW      = $clog2(V_ACTIVE);
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    // One stage covers the pix_req register itself, the rest the source read latency.
    localparam int PD      = RD_LAT + 1;

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        PIX_DIV < 1 || PIX_DIV > 8 || RD_LAT < 0 || RD_LAT > 4) begin : g_bad_params
        $error("vga_timing_gen: illegal timing parameters");
    end

    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          tick, h_wrap, v_wrap, active, hs_raw, vs_raw;
    logic [PD-1:0] act_pipe, hs_pipe, vs_pipe;

    always_comb begin
        tick   = enable && (div_cnt == '0);
        h_wrap = (h_cnt == HW'(H_TOTAL - 1));
        v_wrap = (v_cnt == VW'(V_TOTAL - 1));
        active = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
        hs_raw = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
        vs_raw = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset || !enable) begin
            div_cnt <= '0;
        end else if (div_cnt == DW'(PIX_DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset || !enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset || !enable) begin
            act_pipe <= '0;
            hs_pipe  <= '0;
            vs_pipe  <= '0;
        end else if (tick) begin
            for (int i = PD - 1; i > 0; i--) begin
                act_pipe[i] <= act_pipe[i-1];
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
            end
            act_pipe[0] <= active;
            hs_pipe[0]  <= hs_raw;
            vs_pipe[0]  <= vs_raw;
        end
    end

    // pix_req is a one-cycle strobe with no back-pressure: the source must present the
    // matching pix_rgb on the tick RD_LAT ticks after the tick on which it sees pix_req.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            pix_req     <= 1'b0;
            frame_start <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
        end else begin
            pix_req     <= tick && active;
            frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
            if (tick && active) begin
                pix_x <= h_cnt[XW-1:0];
                pix_y <= v_cnt[YW-1:0];
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset || !enable) begin
            vga_port_red   <= '0;
            vga_port_green <= '0;
            vga_port_blue  <= '0;
            vga_port_hs    <= ~HS_POL;
            vga_port_vs    <= ~VS_POL;
        end else if (tick) begin
            vga_port_red   <= act_pipe[PD-1] ? pix_rgb[3*COLOR_W-1 -: COLOR_W] : '0;
            vga_port_green <= act_pipe[PD-1] ? pix_rgb[2*COLOR_W-1 -: COLOR_W] : '0;
            vga_port_blue  <= act_pipe[PD-1] ? pix_rgb[COLOR_W-1:0]            : '0;
            vga_port_hs    <= hs_pipe[PD-1] ? HS_POL : ~HS_POL;
            vga_port_vs    <= vs_pipe[PD-1] ? VS_POL : ~VS_POL;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a small raster: one PIX_DIV=1 instance with an {x,y,x^y}
// source, one PIX_DIV=2 instance with inverted syncs and a constant colour source.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst, en;
    always #5 clk = ~clk;

    logic        req, fs, hs, vs, req_p, fs_p, hs_p, vs_p;
    logic [1:0]  px, py, px_p, py_p;
    logic [3:0]  red, green, blue, red_p, green_p, blue_p;
    logic [11:0] pix_rgb, src1, src2;
    logic [11:0] rgb_p;

    assign rgb_p   = 12'h5A3;
    assign pix_rgb = src2;
    // Two-tick-latency source: returns {x,y,x^y} for the coordinate it was shown.
    always @(posedge clk) begin
        src1 <= {2'b00, px, 2'b00, py, 2'b00, px ^ py};
        src2 <= src1;
    end

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
                     .V_SYNC(1), .V_BP(1), .COLOR_W(4), .PIX_DIV(1), .RD_LAT(2)) dut (
        .clk_clk(clk), .reset_reset(rst), .enable(en), .pix_req(req), .pix_x(px), .pix_y(py),
        .pix_rgb(pix_rgb), .vga_port_red(red), .vga_port_green(green), .vga_port_blue(blue),
        .vga_port_hs(hs), .vga_port_vs(vs), .frame_start(fs));

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
                     .V_SYNC(1), .V_BP(1), .COLOR_W(4), .PIX_DIV(2), .RD_LAT(2),
                     .HS_POL(1'b1), .VS_POL(1'b1)) dut_p (
        .clk_clk(clk), .reset_reset(rst), .enable(en), .pix_req(req_p), .pix_x(px_p), .pix_y(py_p),
        .pix_rgb(rgb_p), .vga_port_red(red_p), .vga_port_green(green_p), .vga_port_blue(blue_p),
        .vga_port_hs(hs_p), .vga_port_vs(vs_p), .frame_start(fs_p));

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs of dut in cycle n after the first tick (n=0 shows the (0,0) request).
    function automatic void exp_small(input int n, output logic e_req, output logic e_fs,
                                      output logic [11:0] e_rgb, output logic e_hs, output logic e_vs);
        int h, v, t, hh, vv;
        logic act;
        h = n % 8;
        v = (n / 8) % 6;
        e_req = (h < 4) && (v < 3);
        e_fs  = (n % 48) == 0;
        t = n - 3;
        if (t < 0) begin
            e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1;
        end else begin
            hh = t % 8;
            vv = (t / 8) % 6;
            act = (hh < 4) && (vv < 3);
            e_rgb = act ? {4'(hh), 4'(vv), 4'(hh ^ vv)} : 12'h000;
            e_hs  = !(hh >= 5 && hh < 7);
            e_vs  = !(vv == 4);
        end
    endfunction

    // Same raster at two clocks per tick, active-high syncs, constant 5/A/3 colour.
    function automatic void exp_p(input int n, output logic e_req, output logic e_fs,
                                  output logic [3:0] e_red, output logic e_hs, output logic e_vs);
        int k, t, hh, vv;
        k = n / 2;
        e_req = (n % 2 == 0) && ((k % 8) < 4) && (((k / 8) % 6) < 3);
        e_fs  = (n % 2 == 0) && (k % 48 == 0);
        t = k - 3;
        if (t < 0) begin
            e_red = '0; e_hs = 1'b0; e_vs = 1'b0;
        end else begin
            hh = t % 8;
            vv = (t / 8) % 6;
            e_red = ((hh < 4) && (vv < 3)) ? 4'h5 : 4'h0;
            e_hs  = (hh >= 5 && hh < 7);
            e_vs  = (vv == 4);
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b1;
        step(); step();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", req); end
        checks++; if (fs !== 1'b0) begin errors++; $display("FAIL reset_fs got %b exp 0", fs); end
        checks++; if ({px, py} !== 4'h0) begin errors++; $display("FAIL reset_xy got %h exp 0", {px, py}); end
        checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp 000", {red, green, blue}); end
        checks++; if ({hs, vs} !== 2'b11) begin errors++; $display("FAIL reset_sync got %b exp 11", {hs, vs}); end
        checks++; if ({hs_p, vs_p} !== 2'b00) begin errors++; $display("FAIL reset_sync_pol got %b exp 00", {hs_p, vs_p}); end
        checks++; if ({req_p, fs_p} !== 2'b00) begin errors++; $display("FAIL reset_p_strobes got %b exp 00", {req_p, fs_p}); end
    endtask

    task automatic test_frames();
        logic e_req, e_fs, e_hs, e_vs;
        logic [11:0] e_rgb;
        logic [3:0] e_red;
        int req_cnt = 0;
        rst = 1'b0;
        for (int n = 0; n < 192; n++) begin
            step();
            exp_small(n, e_req, e_fs, e_rgb, e_hs, e_vs);
            if (n < 48 && req === 1'b1) req_cnt++;
            checks++; if (req !== e_req) begin errors++; $display("FAIL frame_req n=%0d got %b exp %b", n, req, e_req); end
            checks++; if (fs !== e_fs) begin errors++; $display("FAIL frame_fs n=%0d got %b exp %b", n, fs, e_fs); end
            if (e_req) begin
                checks++;
                if ({px, py} !== {2'(n % 8), 2'((n / 8) % 6)}) begin
                    errors++; $display("FAIL frame_xy n=%0d got %h exp %h", n, {px, py}, {2'(n % 8), 2'((n / 8) % 6)});
                end
            end
            checks++; if ({red, green, blue} !== e_rgb) begin errors++; $display("FAIL frame_rgb n=%0d got %h exp %h", n, {red, green, blue}, e_rgb); end
            checks++; if ({hs, vs} !== {e_hs, e_vs}) begin errors++; $display("FAIL frame_sync n=%0d got %b exp %b", n, {hs, vs}, {e_hs, e_vs}); end
            exp_p(n, e_req, e_fs, e_red, e_hs, e_vs);
            checks++; if ({req_p, fs_p} !== {e_req, e_fs}) begin errors++; $display("FAIL div2_strobes n=%0d got %b exp %b", n, {req_p, fs_p}, {e_req, e_fs}); end
            checks++; if (red_p !== e_red) begin errors++; $display("FAIL div2_red n=%0d got %h exp %h", n, red_p, e_red); end
            checks++; if ({hs_p, vs_p} !== {e_hs, e_vs}) begin errors++; $display("FAIL div2_sync n=%0d got %b exp %b", n, {hs_p, vs_p}, {e_hs, e_vs}); end
        end
        checks++; if (req_cnt != 12) begin errors++; $display("FAIL frame_req_count got %0d exp 12", req_cnt); end
    endtask

    task automatic test_enable_drop();
        logic e_req, e_fs, e_hs, e_vs;
        logic [11:0] e_rgb;
        rst = 1'b1; en = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 0; n < 10; n++) step();
        checks++; if ({req, px, py} !== 5'b1_01_01) begin errors++; $display("FAIL drop_pre got %b exp 10101", {req, px, py}); end
        en = 1'b0;
        step();
        checks++; if ({req, fs} !== 2'b00) begin errors++; $display("FAIL drop_strobes got %b exp 00", {req, fs}); end
        checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL drop_rgb got %h exp 000", {red, green, blue}); end
        checks++; if ({hs, vs, hs_p, vs_p} !== 4'b1100) begin errors++; $display("FAIL drop_sync got %b exp 1100", {hs, vs, hs_p, vs_p}); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if ({req, fs, req_p} !== 3'b000) begin errors++; $display("FAIL drop_idle i=%0d got %b exp 000", i, {req, fs, req_p}); end
        end
        en = 1'b1;
        for (int n = 0; n < 24; n++) begin
            step();
            exp_small(n, e_req, e_fs, e_rgb, e_hs, e_vs);
            checks++; if ({req, fs} !== {e_req, e_fs}) begin errors++; $display("FAIL reen_strobes n=%0d got %b exp %b", n, {req, fs}, {e_req, e_fs}); end
            checks++; if ({red, green, blue} !== e_rgb) begin errors++; $display("FAIL reen_rgb n=%0d got %h exp %h", n, {red, green, blue}, e_rgb); end
            checks++; if ({hs, vs} !== {e_hs, e_vs}) begin errors++; $display("FAIL reen_sync n=%0d got %b exp %b", n, {hs, vs}, {e_hs, e_vs}); end
        end
        checks++; if (fs_p !== 1'b0) begin errors++; $display("FAIL reen_p_fs got %b exp 0", fs_p); end
    endtask

    task automatic test_reset_mid();
        logic e_req, e_fs, e_hs, e_vs;
        logic [11:0] e_rgb;
        rst = 1'b1; en = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 0; n < 13; n++) step();
        checks++; if ({red, green, blue} !== 12'h110) begin errors++; $display("FAIL mid_pre_rgb got %h exp 110", {red, green, blue}); end
        checks++; if ({px, py} !== 4'b11_01) begin errors++; $display("FAIL mid_pre_xy got %b exp 1101", {px, py}); end
        rst = 1'b1;
        step();
        checks++; if ({req, fs, px, py} !== 6'b0) begin errors++; $display("FAIL mid_rst_req got %b exp 000000", {req, fs, px, py}); end
        checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL mid_rst_rgb got %h exp 000", {red, green, blue}); end
        checks++; if ({hs, vs, hs_p, vs_p} !== 4'b1100) begin errors++; $display("FAIL mid_rst_sync got %b exp 1100", {hs, vs, hs_p, vs_p}); end
        rst = 1'b0;
        for (int n = 0; n < 49; n++) begin
            step();
            exp_small(n, e_req, e_fs, e_rgb, e_hs, e_vs);
            checks++; if ({req, fs} !== {e_req, e_fs}) begin errors++; $display("FAIL restart_strobes n=%0d got %b exp %b", n, {req, fs}, {e_req, e_fs}); end
            checks++; if ({red, green, blue} !== e_rgb) begin errors++; $display("FAIL restart_rgb n=%0d got %h exp %h", n, {red, green, blue}, e_rgb); end
            if (n == 1) begin
                checks++; if ({px, py} !== 4'b01_00) begin errors++; $display("FAIL restart_xy got %b exp 0100", {px, py}); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        test_reset();
        test_frames();
        test_enable_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
